// File: rtl/wide_add_seq.sv
// Multi-precision sequential adder: one 16-bit prefix adder slice reused per slice, carry-in applied by a +1 pass.
// Optional signed-overflow output enabled by defining WIDE_ADD_SEQ_SOVF_EN.

module wide_add_seq_slice (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);
  // Kogge-Stone generate/propagate tree, no carry-in
  always_comb begin
    logic [15:0] g, p, gn, pn;
    g = a & b;
    p = a ^ b;
    for (int unsigned lvl = 0; lvl < 4; lvl++) begin
      gn = g;
      pn = p;
      for (int unsigned i = 0; i < 16; i++) begin
        if (i >= (32'd1 << lvl)) begin
          gn[i] = g[i] | (p[i] & g[i - (32'd1 << lvl)]);
          pn[i] = p[i] & p[i - (32'd1 << lvl)];
        end
      end
      g = gn;
      p = pn;
    end
    sum  = a ^ b ^ {g[14:0], 1'b0};
    cout = g[15];
  end
endmodule

module wide_add_seq #(
  parameter int NSLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*NSLICE-1:0]  a,
  input  logic [16*NSLICE-1:0]  b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef WIDE_ADD_SEQ_SOVF_EN
  output logic                  ovf,
`endif
  output logic [16*NSLICE-1:0]  sum,
  output logic                  cout
);
  localparam int W  = 16 * NSLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, ADD, INC, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic          pend;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [15:0]   op_a;
  logic [15:0]   op_b;
  logic [15:0]   add_sum;
  logic          add_cout;
  logic          last;

  assign last = (idx == LAST);

  always_comb begin
    op_a = a_r[{idx, 4'b0000} +: 16];
    op_b = b_r[{idx, 4'b0000} +: 16];
    if (state == INC) begin
      op_a = sum[{idx, 4'b0000} +: 16];
      op_b = 16'h0001;
    end
  end

  wide_add_seq_slice u_slice (
    .a    (op_a),
    .b    (op_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef WIDE_ADD_SEQ_SOVF_EN
  // Final MSB is the top bit of the slice result being written on entry to DONE
  logic ovf_next;
  assign ovf_next = (a_r[W-1] == b_r[W-1]) && (add_sum[15] != a_r[W-1]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      pend      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef WIDE_ADD_SEQ_SOVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            carry    <= cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ADD;
          end
        end
        ADD: begin
          sum[{idx, 4'b0000} +: 16] <= add_sum;
          pend <= add_cout;
          if (carry) begin
            state <= INC;
          end else begin
            carry <= add_cout;
            if (last) begin
              state     <= DONE;
              out_valid <= 1'b1;
              cout      <= add_cout;
`ifdef WIDE_ADD_SEQ_SOVF_EN
              ovf       <= ovf_next;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        INC: begin
          sum[{idx, 4'b0000} +: 16] <= add_sum;
          carry <= pend | add_cout;
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= pend | add_cout;
`ifdef WIDE_ADD_SEQ_SOVF_EN
            ovf       <= ovf_next;
`endif
          end else begin
            idx   <= idx + 1'b1;
            state <= ADD;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
